// File: rtl/dbus_map_pkg.sv
// Data-bus address map and FSM state type shared by the interconnect and its decoder.
package dbus_map_pkg;

    localparam int unsigned MAP_ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ERR,
        ST_DRAIN
    } type_dbus_state_e;

    // Rows: 0 DMEM, 1 CLINT, 2 UART, 3 GPIO
    localparam logic [31:0] SLV_BASE [MAP_ROWS] = '{
        32'h8000_0000, 32'h0200_0000, 32'h9000_0000, 32'h9000_0100
    };
    localparam logic [31:0] SLV_MASK [MAP_ROWS] = '{
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00
    };

    function automatic logic addr_match(input logic [31:0] addr, input int unsigned row);
        return (addr & SLV_MASK[row]) == SLV_BASE[row];
    endfunction

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational address decoder: one-hot slave hit vector, lowest index wins on overlap.
module dbus_addr_decode #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit
);
    import dbus_map_pkg::*;

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit && addr_match(32'(addr), i)) begin
                hit[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbus_interconnect.sv
// Single-master data-bus interconnect between the LSU port and NUM_SLAVES slave ports.
// Optional request timeout is built in when DBUS_TIMEOUT_EN is defined.
module dbus_interconnect #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         lsu_req,
    input  logic                         lsu_w_en,
    input  logic [ADDR_W-1:0]            lsu_addr,
    input  logic [DATA_W-1:0]            lsu_wdata,
    input  logic [DATA_W/8-1:0]          lsu_sel,
    input  logic                         lsu_flush,
    output logic                         lsu_ack,
    output logic                         lsu_err,
    output logic [DATA_W-1:0]            lsu_rdata,
    output logic [NUM_SLAVES-1:0]        slv_req,
    output logic                         slv_w_en,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic [DATA_W-1:0]            slv_wdata,
    output logic [DATA_W/8-1:0]          slv_sel,
    input  logic [NUM_SLAVES-1:0]        slv_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata
);
    import dbus_map_pkg::*;

    type_dbus_state_e      state;
    logic [NUM_SLAVES-1:0] dec_hit;
    logic                  dec_any;
    logic                  sel_ack;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  err_ack_q;
    logic                  accept;
    logic                  req_done;
    logic                  to_expire;

    dbus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W)
    ) u_decode (
        .addr    (lsu_addr),
        .hit     (dec_hit),
        .any_hit (dec_any)
    );

    // slv_req is one-hot, so an AND-OR mux selects the active slave's data
    always_comb begin
        sel_ack   = |(slv_ack & slv_req);
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (slv_req[i]) begin
                sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Error ack is registered out of ERR; the LSU request seen alongside it is not a new access
    assign accept    = (state == ST_IDLE) && lsu_req && !lsu_flush && !err_ack_q;
    assign req_done  = (state == ST_REQ) && sel_ack && !lsu_flush;
    assign lsu_ack   = req_done || err_ack_q;
    assign lsu_err   = err_ack_q;
    assign lsu_rdata = req_done ? sel_rdata : '0;

`ifdef DBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    assign to_expire = (state == ST_REQ || state == ST_DRAIN)
                       && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            to_cnt <= '0;
        end else if ((state == ST_REQ || state == ST_DRAIN) && !sel_ack && !to_expire) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // No timeout hardware in this build; REQ and DRAIN wait for the slave
    assign to_expire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slv_req   <= '0;
            slv_w_en  <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_sel   <= '0;
            err_ack_q <= 1'b0;
        end else begin
            err_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        slv_w_en  <= lsu_w_en;
                        slv_addr  <= lsu_addr;
                        slv_wdata <= lsu_wdata;
                        slv_sel   <= lsu_sel;
                        if (dec_any) begin
                            slv_req <= dec_hit;
                            state   <= ST_REQ;
                        end else begin
                            state   <= ST_ERR;
                        end
                    end
                end
                ST_REQ: begin
                    if (sel_ack) begin
                        slv_req <= '0;
                        state   <= ST_IDLE;
                    end else if (to_expire) begin
                        slv_req <= '0;
                        state   <= lsu_flush ? ST_IDLE : ST_ERR;
                    end else if (lsu_flush) begin
                        state   <= ST_DRAIN;
                    end
                end
                ST_ERR: begin
                    err_ack_q <= !lsu_flush;
                    state     <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (sel_ack || to_expire) begin
                        slv_req <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Self-checking bench for dbus_interconnect: directed scenarios plus randomized accesses
// checked against a window-based address map and latency model.
`timescale 1ns/1ps
module tb_dbus_interconnect;

    localparam int NS         = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int BOUND      = 60;

    // Reference map as [lo, lo+size) windows
    localparam logic [31:0] REF_LO   [NS] = '{32'h8000_0000, 32'h0200_0000, 32'h9000_0000, 32'h9000_0100};
    localparam logic [31:0] REF_SIZE [NS] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0100};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lsu_req, lsu_w_en, lsu_flush;
    logic [31:0]   lsu_addr, lsu_wdata;
    logic [3:0]    lsu_sel;
    logic          lsu_ack, lsu_err;
    logic [31:0]   lsu_rdata;
    logic [NS-1:0] slv_req;
    logic          slv_w_en;
    logic [31:0]   slv_addr, slv_wdata;
    logic [3:0]    slv_sel;
    logic [NS-1:0] slv_ack;
    logic [NS*32-1:0] slv_rdata;

    int total = 0;
    int bad   = 0;

    int          age    [NS];
    logic [31:0] rd_now [NS];

    int          r_ack_cyc;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_snap [NS];
    logic [NS-1:0] r_req_seen;
    int          r_req_cyc;
    int          r_viol;
    bit          r_timed_out;

    always #5 clk = ~clk;

    dbus_interconnect #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_req   (lsu_req),
        .lsu_w_en  (lsu_w_en),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_sel   (lsu_sel),
        .lsu_flush (lsu_flush),
        .lsu_ack   (lsu_ack),
        .lsu_err   (lsu_err),
        .lsu_rdata (lsu_rdata),
        .slv_req   (slv_req),
        .slv_w_en  (slv_w_en),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_sel   (slv_sel),
        .slv_ack   (slv_ack),
        .slv_rdata (slv_rdata)
    );

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= REF_LO[i] && (a - REF_LO[i]) < REF_SIZE[i]) return i;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            lsu_req   = 1'b0;
            lsu_flush = 1'b0;
            slv_ack   = '0;
        end
    endtask

    // Drives one LSU access (cycle 0 = acceptance cycle) and plays all slaves; slave i acks
    // once its slv_req has been high for more than lat cycles. Unselected slaves ack randomly.
    task automatic run_access(input logic [31:0] addr, input logic w, input logic [31:0] wd,
                              input logic [3:0] sel, input int lat, input int flush_at, input int tail);
        int c;
        int end_c;
        bit done;
        r_ack_cyc = -1; r_err = 1'b0; r_rdata = '0; r_req_seen = '0; r_req_cyc = 0; r_viol = 0;
        for (int i = 0; i < NS; i++) begin
            age[i] = 0;
            r_snap[i] = '0;
        end
        end_c = -1; done = 1'b0; c = 0;
        while (!done && c < BOUND) begin
            @(posedge clk); #1;
            if (c == 0) begin
                lsu_req = 1'b1; lsu_w_en = w; lsu_addr = addr; lsu_wdata = wd; lsu_sel = sel;
            end
            if (r_ack_cyc >= 0 || (flush_at >= 0 && c > flush_at)) lsu_req = 1'b0;
            lsu_flush = (c == flush_at);
            for (int i = 0; i < NS; i++) begin
                age[i]    = slv_req[i] ? age[i] + 1 : 0;
                rd_now[i] = $urandom;
                slv_rdata[i*32 +: 32] = rd_now[i];
                if (slv_req[i]) slv_ack[i] = (age[i] > lat);
                else            slv_ack[i] = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            if (lsu_ack) begin
                if (r_ack_cyc >= 0) r_viol++;
                else begin
                    r_ack_cyc = c; r_err = lsu_err; r_rdata = lsu_rdata;
                    for (int i = 0; i < NS; i++) r_snap[i] = rd_now[i];
                end
            end else if (lsu_err !== 1'b0 || lsu_rdata !== 32'h0) begin
                r_viol++;
            end
            if (slv_req !== '0) begin
                r_req_seen = r_req_seen | slv_req;
                r_req_cyc++;
                if (!$onehot(slv_req) || slv_w_en !== w || slv_addr !== addr ||
                    slv_wdata !== wd || slv_sel !== sel) r_viol++;
            end
            if (end_c < 0 && (r_ack_cyc >= 0 || (flush_at >= 0 && c > flush_at && slv_req == '0)))
                end_c = c;
            if (end_c >= 0 && c >= end_c + tail) done = 1'b1;
            c++;
        end
        r_timed_out = !done;
    endtask

    // Checks a completed (unflushed) access against the map/latency model
    task automatic expect_complete(input string name, input logic [31:0] addr, input int lat);
        int idx;
        int exp_ack;
        logic [31:0] exp_rd;
        logic [NS-1:0] exp_req;
        idx     = ref_decode(addr);
        exp_ack = (idx >= 0) ? 1 + lat : 2;
        exp_rd  = (idx >= 0) ? r_snap[idx] : 32'h0;
        exp_req = (idx >= 0) ? NS'(1) << idx : '0;
        total++;
        if (r_ack_cyc !== exp_ack || r_timed_out) begin
            bad++;
            $display("FAIL %s ack_cycle: got %0d expected %0d (addr %h)", name, r_ack_cyc, exp_ack, addr);
        end
        total++;
        if (r_err !== (idx < 0)) begin
            bad++;
            $display("FAIL %s err: got %0b expected %0b (addr %h)", name, r_err, idx < 0, addr);
        end
        total++;
        if (r_rdata !== exp_rd) begin
            bad++;
            $display("FAIL %s rdata: got %h expected %h", name, r_rdata, exp_rd);
        end
        total++;
        if (r_req_seen !== exp_req || r_req_cyc !== ((idx >= 0) ? lat + 1 : 0)) begin
            bad++;
            $display("FAIL %s slv_req: got %b/%0d cycles expected %b/%0d cycles", name,
                     r_req_seen, r_req_cyc, exp_req, (idx >= 0) ? lat + 1 : 0);
        end
        total++;
        if (r_viol !== 0) begin
            bad++;
            $display("FAIL %s protocol: got %0d violations expected 0", name, r_viol);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lsu_req = 1'b1; lsu_w_en = 1'b1; lsu_addr = 32'h8000_0000; lsu_wdata = $urandom;
        lsu_sel = 4'hF; lsu_flush = 1'b0; slv_ack = '1; slv_rdata = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({lsu_ack, lsu_err, lsu_rdata, slv_req, slv_w_en, slv_addr, slv_wdata, slv_sel} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h req=%b w=%b addr=%h wdata=%h sel=%b expected all 0",
                     lsu_ack, lsu_err, lsu_rdata, slv_req, slv_w_en, slv_addr, slv_wdata, slv_sel);
        end
        @(posedge clk); #1;
        lsu_req = 1'b0; slv_ack = '0; rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_read_dmem();
        run_access(32'h8000_0010, 1'b0, $urandom, 4'hF, 1, -1, 2);
        expect_complete("read_dmem", 32'h8000_0010, 1);
    endtask

    task automatic test_write_gpio();
        int lat;
        lat = $urandom_range(1, 4);
        run_access(32'h9000_0104, 1'b1, 32'h0000_00A5, 4'b0001, lat, -1, 2);
        expect_complete("write_gpio", 32'h9000_0104, lat);
    endtask

    task automatic test_unmapped();
        run_access(32'h4000_0000, 1'b0, $urandom, 4'hF, 1, -1, 2);
        expect_complete("unmapped", 32'h4000_0000, 1);
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [8] = '{32'h8000_FFFF, 32'h8001_0000, 32'h0200_FFFF, 32'h01FF_FFFC,
                                    32'h9000_00FF, 32'h9000_0100, 32'h9000_01FF, 32'h9000_0200};
        for (int i = 0; i < 8; i++) begin
            run_access(addrs[i], 1'b0, $urandom, 4'hF, 2, -1, 1);
            expect_complete("boundary", addrs[i], 2);
        end
    endtask

    // flush_at relative to acceptance; exp_req_cyc is how long slv_req must stay up
    task automatic check_flushed(input string name, input logic [31:0] addr, input int lat,
                                 input int flush_at, input logic [NS-1:0] exp_req, input int exp_req_cyc);
        run_access(addr, 1'b0, $urandom, 4'hF, lat, flush_at, 2);
        total++;
        if (r_ack_cyc !== -1 || r_timed_out) begin
            bad++;
            $display("FAIL %s no_ack: got ack at cycle %0d expected none", name, r_ack_cyc);
        end
        total++;
        if (r_req_seen !== exp_req || r_req_cyc !== exp_req_cyc || r_viol !== 0) begin
            bad++;
            $display("FAIL %s drain: got req=%b/%0d cycles viol=%0d expected %b/%0d cycles viol=0",
                     name, r_req_seen, r_req_cyc, r_viol, exp_req, exp_req_cyc);
        end
    endtask

    task automatic test_flush();
        check_flushed("flush_drain", 32'h9000_0040, 5, 2, 4'b0100, 6);
        run_access(32'h8000_0100, 1'b0, $urandom, 4'hF, 2, -1, 2);
        expect_complete("after_drain", 32'h8000_0100, 2);
        check_flushed("flush_with_ack", 32'h9000_0010, 3, 4, 4'b0100, 4);
        check_flushed("flush_in_err", 32'h4000_1000, 1, 1, 4'b0000, 0);
        check_flushed("flush_with_req", 32'h8000_0020, 1, 0, 4'b0000, 0);
    endtask

    task automatic test_timeout();
`ifdef DBUS_TIMEOUT_EN
        run_access(32'h0200_0040, 1'b0, $urandom, 4'hF, 1000, -1, 2);
        total++;
        if (r_req_cyc !== TB_TIMEOUT || r_req_seen !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_req: got %b/%0d cycles expected 0010/%0d cycles", r_req_seen, r_req_cyc, TB_TIMEOUT);
        end
        total++;
        if (r_ack_cyc !== TB_TIMEOUT + 2 || r_err !== 1'b1 || r_rdata !== 32'h0 || r_viol !== 0) begin
            bad++;
            $display("FAIL timeout_ack: got cycle=%0d err=%b rdata=%h viol=%0d expected cycle=%0d err=1 rdata=0 viol=0",
                     r_ack_cyc, r_err, r_rdata, r_viol, TB_TIMEOUT + 2);
        end
`else
        run_access(32'h0200_0040, 1'b0, $urandom, 4'hF, 40, -1, 2);
        expect_complete("no_timeout", 32'h0200_0040, 40);
`endif
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_w_en = 1'b0; lsu_addr = 32'h0200_0008; lsu_sel = 4'hF; lsu_flush = 1'b0; slv_ack = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (slv_req !== 4'b0010) begin
            bad++;
            $display("FAIL reset_mid_pre: got slv_req=%b expected 0010", slv_req);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({lsu_ack, lsu_err, lsu_rdata, slv_req, slv_w_en, slv_addr, slv_wdata, slv_sel} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got ack=%b req=%b addr=%h expected all 0", lsu_ack, slv_req, slv_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; lsu_req = 1'b0;
        run_access(32'h8000_0044, 1'b1, $urandom, 4'b1100, 2, -1, 2);
        expect_complete("after_reset", 32'h8000_0044, 2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6] = '{32'h8000_0000, 32'h4000_0004, 32'h9000_0108, 32'h0000_0000,
                                    32'h0200_0010, 32'h9000_0020};
        for (int i = 0; i < 6; i++) begin
            int lat;
            lat = $urandom_range(1, 3);
            run_access(addrs[i], i[0], $urandom, 4'(i + 1), lat, -1, 0);
            expect_complete("back_to_back", addrs[i], lat);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int lat;
            int idx;
            int cls;
            cls = $urandom_range(0, 4);
            lat = $urandom_range(1, 4);
            case (cls)
                0: a = 32'h8000_0000 + $urandom_range(0, 32'hFFFF);
                1: a = 32'h0200_0000 + $urandom_range(0, 32'hFFFF);
                2: a = 32'h9000_0000 + $urandom_range(0, 32'hFF);
                3: a = 32'h9000_0100 + $urandom_range(0, 32'hFF);
                default: a = $urandom;
            endcase
            idx = ref_decode(a);
            if ($urandom_range(0, 4) == 0) begin
                int f;
                f = (idx >= 0) ? $urandom_range(1, 1 + lat) : 1;
                check_flushed("random_flush", a, lat, f, (idx >= 0) ? NS'(1) << idx : '0,
                              (idx >= 0) ? lat + 1 : 0);
            end else begin
                run_access(a, $urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)), lat, -1,
                           $urandom_range(0, 2));
                expect_complete("random", a, lat);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lsu_req = 1'b0; lsu_w_en = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_sel = '0;
        lsu_flush = 1'b0; slv_ack = '0; slv_rdata = '0; rst_n = 1'b0;
        test_reset();
        test_read_dmem();
        test_write_gpio();
        test_unmapped();
        test_boundaries();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
